sync_register_e1of4: RTL
========================

SYNC_REGISTER_E1OF4 -- requirements
Module: sync_register_e1of4

Interface
REQ-001 SHALL have parameter INIT_DATA, default 2'b00: stored value after reset.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth (min 2), used only when QDI_SYNC_EN is defined.
REQ-003 SHALL have port CLK, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port RESET, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port Cx, input, 3: 1of3 control token; rail0=read, rail1=write, rail2=write+read.
REQ-006 SHALL have port Cxe, output, 1: control enable; high=ready, low=acknowledge.
REQ-007 SHALL have port Tx, input, 4: 1of4 write-data token; rail k encodes value k.
REQ-008 SHALL have port Txe, output, 1: data enable; same polarity as Cxe.
REQ-009 SHALL have port Rx, output, 4: 1of4 read-data token.
REQ-010 SHALL have port Rxe, input, 1: receiver enable; high=ready, low=acknowledge.
REQ-011 SHALL have port ERR, output, 1: sticky illegal-code flag.

Function
REQ-012 SHALL use the four-phase protocol on all channels: valid when exactly one rail is high, neutral when all rails are low.
REQ-013 SHALL implement FSM states IDLE, WAIT_DATA, ACK_IN, SEND, RTZ.
REQ-014 IDLE: on a valid Cx read token, SHALL go to ACK_IN; on a write or write+read token, SHALL go to WAIT_DATA.
REQ-015 WAIT_DATA: on a valid Tx token, SHALL latch the decoded 2-bit value and go to ACK_IN.
REQ-016 ACK_IN: SHALL drive Cxe=0, plus Txe=0 when data was consumed; SHALL hold until Cx and Tx are both neutral.
REQ-017 Leaving ACK_IN: write SHALL update the register and return to IDLE; read SHALL go to SEND; write+read SHALL capture the pre-write value for output, update the register, then go to SEND.
REQ-018 SEND: SHALL raise the Rx rail matching the output value only while Rxe=1; SHALL go to RTZ when Rxe=0.
REQ-019 RTZ: SHALL drive Rx=0000 and return to IDLE when Rxe=1.
REQ-020 SHALL keep Cxe and Txe low from ACK_IN through RTZ, so no new token is accepted until the output handshake completes.
REQ-021 Cxe/Txe SHALL return high on the cycle IDLE is re-entered.
REQ-022 Txe SHALL never fall for a read-only token.
REQ-023 Tx SHALL be ignored outside WAIT_DATA.
REQ-024 A token with more than one hot rail on Cx (IDLE) or Tx (WAIT_DATA) SHALL set ERR, SHALL NOT be acknowledged, and SHALL leave the FSM state unchanged.
REQ-025 Outputs Cxe, Txe, Rx and ERR SHALL be registered, glitch-free, with no combinational input-to-output path.
REQ-026 Latency, with QDI_SYNC_EN: Cxe SHALL fall SYNC_STAGES+1 cycles after a Cx rail rises.
REQ-027 Latency, without QDI_SYNC_EN: Cxe SHALL fall 1 cycle after a Cx rail rises.

Reset
REQ-028 RESET high SHALL immediately force: state IDLE, register=INIT_DATA, Cxe=1, Txe=1, Rx=0000, ERR=0, synchronizers cleared.
REQ-029 Reset mid-handshake SHALL abandon the token; the sender SHALL see enables high after reset.

Configuration
REQ-030 With QDI_SYNC_EN defined, Cx, Tx and Rxe SHALL each pass through a SYNC_STAGES-deep flop synchronizer before use.
REQ-031 Without QDI_SYNC_EN, inputs SHALL be sampled directly (same-clock-domain sender/receiver); function is otherwise identical.

Structure
REQ-032 Shared package qdi_pkg SHALL hold the FSM state enum, control-rail index constants (CTRL_READ=0, CTRL_WRITE=1, CTRL_WR_RD=2), a one-hot validity function, and 1of4 encode/decode functions.
REQ-033 SHALL instantiate sub-module qdi_sync (N-bit, parameterized-depth synchronizer), used only under QDI_SYNC_EN.

Verification
REQ-034 Reset, then read: Cx=001 -> Rx=0001 (INIT_DATA=0); Txe stays 1; Cxe low until Rx handshake completes.
REQ-035 Write Tx=0100 with Cx=010, then read -> Rx=0100; no Rx activity during the write.
REQ-036 Stored 2'b10, then write+read Tx=0010 (value 1) -> Rx=0100 (old value 2); following read -> Rx=0010.
REQ-037 Cx=011 in IDLE -> ERR=1, Cxe stays 1; then neutral Cx and a legal read -> normal response, ERR remains 1.
REQ-038 Hold Rxe=0 before a read -> Rx stays 0000 until Rxe=1, then the rail rises; Cxe stays low throughout.
REQ-039 Assert RESET while in SEND -> Rx=0000, Cxe=Txe=1, register=INIT_DATA, next read returns INIT_DATA.

Source files
------------

// File: rtl/qdi_pkg.sv
// rtl/qdi_pkg.sv - shared types, rail indices and 1of4 helpers for the QDI register
package qdi_pkg;

    // Handshake FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_ACK_IN    = 3'd2,
        ST_SEND      = 3'd3,
        ST_RTZ       = 3'd4
    } state_t;

    // Operation latched from the control token
    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_WR_RD = 2'd2
    } op_t;

    // Control rail indices on the 1of3 Cx channel
    localparam int CTRL_READ  = 0;
    localparam int CTRL_WRITE = 1;
    localparam int CTRL_WR_RD = 2;

    // True when exactly one rail is high
    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    // 1of4 rail to 2-bit value; only called on a validated token
    function automatic logic [1:0] decode_1of4(input logic [3:0] v);
        logic [1:0] r;
        case (v)
            4'b0010: r = 2'd1;
            4'b0100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // 2-bit value to 1of4 rail
    function automatic logic [3:0] encode_1of4(input logic [1:0] k);
        logic [3:0] r;
        r = 4'b0001 << k;
        return r;
    endfunction

endpackage

// File: rtl/qdi_sync.sv
// rtl/qdi_sync.sv - N-bit flop synchronizer with configurable depth
module qdi_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sync [STAGES];

    // Shift the inputs through the chain; reset clears every stage
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/sync_register_e1of4.sv
// rtl/sync_register_e1of4.sv - 2-bit QDI register on 1of3/1of4 four-phase channels; QDI_SYNC_EN adds input synchronizers
module sync_register_e1of4
    import qdi_pkg::*;
#(
    parameter logic [1:0] INIT_DATA   = 2'b00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [2:0] Cx,
    output logic       Cxe,
    input  logic [3:0] Tx,
    output logic       Txe,
    output logic [3:0] Rx,
    input  logic       Rxe,
    output logic       ERR
);

    // A one-stage synchronizer is not a synchronizer
    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("SYNC_STAGES must be at least 2");
    end

    logic [2:0] w_cx;
    logic [3:0] w_tx;
    logic       w_rxe;

`ifdef QDI_SYNC_EN
    logic [7:0] w_sync_q;

    qdi_sync #(
        .WIDTH  (8),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk (CLK),
        .i_rst (RESET),
        .i_d   ({Rxe, Tx, Cx}),
        .o_q   (w_sync_q)
    );

    assign w_cx  = w_sync_q[2:0];
    assign w_tx  = w_sync_q[6:3];
    assign w_rxe = w_sync_q[7];
`else
    assign w_cx  = Cx;
    assign w_tx  = Tx;
    assign w_rxe = Rxe;
`endif

    state_t     r_state;
    op_t        r_op;
    logic [1:0] r_data;
    logic [1:0] r_wdata;
    logic [1:0] r_out;
    logic       r_cxe;
    logic       r_txe;
    logic [3:0] r_rx;
    logic       r_err;

    // Handshake FSM; every output is a flop so no input reaches an output combinationally
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_op    <= OP_READ;
            r_data  <= INIT_DATA;
            r_wdata <= 2'd0;
            r_out   <= 2'd0;
            r_cxe   <= 1'b1;
            r_txe   <= 1'b1;
            r_rx    <= 4'b0000;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cx != 3'b000) begin
                        if (!is_one_hot({1'b0, w_cx})) begin
                            r_err <= 1'b1;
                        end else if (w_cx[CTRL_READ]) begin
                            r_op    <= OP_READ;
                            r_cxe   <= 1'b0;
                            r_state <= ST_ACK_IN;
                        end else begin
                            r_op    <= w_cx[CTRL_WRITE] ? OP_WRITE : OP_WR_RD;
                            r_state <= ST_WAIT_DATA;
                        end
                    end
                end
                ST_WAIT_DATA: begin
                    if (w_tx != 4'b0000) begin
                        if (!is_one_hot(w_tx)) begin
                            r_err <= 1'b1;
                        end else begin
                            r_wdata <= decode_1of4(w_tx);
                            r_cxe   <= 1'b0;
                            r_txe   <= 1'b0;
                            r_state <= ST_ACK_IN;
                        end
                    end
                end
                ST_ACK_IN: begin
                    if ((w_cx == 3'b000) && (w_tx == 4'b0000)) begin
                        case (r_op)
                            OP_WRITE: begin
                                r_data  <= r_wdata;
                                r_cxe   <= 1'b1;
                                r_txe   <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                            OP_READ: begin
                                r_out   <= r_data;
                                r_state <= ST_SEND;
                            end
                            default: begin
                                r_out   <= r_data;
                                r_data  <= r_wdata;
                                r_state <= ST_SEND;
                            end
                        endcase
                    end
                end
                ST_SEND: begin
                    if (w_rxe) begin
                        r_rx <= encode_1of4(r_out);
                    end else if (r_rx != 4'b0000) begin
                        r_rx    <= 4'b0000;
                        r_state <= ST_RTZ;
                    end
                end
                ST_RTZ: begin
                    r_rx <= 4'b0000;
                    if (w_rxe) begin
                        r_cxe   <= 1'b1;
                        r_txe   <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Cxe = r_cxe;
    assign Txe = r_txe;
    assign Rx  = r_rx;
    assign ERR = r_err;

endmodule
